ready_qualifier: RTL and testbench
==================================

READY_QUALIFIER -- requirements
Module: ready_qualifier

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent input channels (>=1).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser flops per channel (>=2).
REQ-003 SHALL have parameter ASSERT_CYCLES, default 4096: consecutive synced-high samples needed to assert ready (>=1).
REQ-004 SHALL have parameter DEASSERT_CYCLES, default 1: consecutive synced-low samples needed to drop ready (>=1).
REQ-005 SHALL have parameter DROP_W, default 8: width of the drop event counter.
REQ-006 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port sig_in  input  NUM_CH  asynchronous raw level per channel.
REQ-009 SHALL have port clr_drops  input  1  synchronous clear of drop_cnt.
REQ-010 SHALL have port ready  output  NUM_CH  registered qualified level per channel.
REQ-011 SHALL have port rise  output  NUM_CH  one-cycle pulse, registered, when ready[i] goes 0->1.
REQ-012 SHALL have port fall  output  NUM_CH  one-cycle pulse, registered, when ready[i] goes 1->0.
REQ-013 SHALL have port all_ready  output  1  combinational AND of ready.
REQ-014 SHALL have port drop_cnt  output  DROP_W  saturating count of cycles with any fall.

Function
REQ-015 SHALL pass each sig_in[i] through a SYNC_STAGES flop chain; s[i] is the last stage output.
REQ-016 SHALL run one 4-state FSM per channel: LOW, QUAL_HI, HIGH, QUAL_LO; ready[i]=1 only in HIGH and QUAL_LO.
REQ-017 SHALL use a per-channel counter of width clog2(max(ASSERT_CYCLES,DEASSERT_CYCLES)+1).
REQ-018 LOW: s=1 -> QUAL_HI, ctr=1; or directly HIGH if ASSERT_CYCLES==1; s=0 -> stay, ctr=0.
REQ-019 QUAL_HI: s=0 -> LOW, ctr=0; s=1 and ctr==ASSERT_CYCLES-1 -> HIGH; else ctr+1.
REQ-020 HIGH: s=0 -> QUAL_LO, ctr=1; or directly LOW if DEASSERT_CYCLES==1; s=1 -> stay, ctr=0.
REQ-021 QUAL_LO: s=1 -> HIGH, ctr=0, no pulse; s=0 and ctr==DEASSERT_CYCLES-1 -> LOW; else ctr+1.
REQ-022 SHALL update ready[i] on the same edge as the entry into HIGH or LOW; latency raw edge -> ready = SYNC_STAGES+ASSERT_CYCLES (rise) or SYNC_STAGES+DEASSERT_CYCLES (fall) clocks.
REQ-023 SHALL assert rise[i]/fall[i] for exactly the cycle in which ready[i] first shows the new value; never both at once.
REQ-024 A glitch shorter than the qualify window SHALL leave ready unchanged and produce no pulse.
REQ-025 drop_cnt SHALL increment by 1 in any cycle with at least one fall bit set, regardless of how many channels fall.
REQ-026 drop_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-027 clr_drops SHALL set drop_cnt to 0 on the next edge; clr_drops wins over a simultaneous increment.
REQ-028 Channels SHALL be fully independent; simultaneous transitions on several channels handled in parallel.

Reset
REQ-029 rst SHALL clear synchronisers, FSMs to LOW, counters, ready, rise, fall and drop_cnt to 0; all_ready=0 whenever NUM_CH>=1 after reset.
REQ-030 rst asserted mid-qualification or in HIGH SHALL drop ready to 0 without asserting fall and without counting a drop.
REQ-031 rst SHALL take priority over clr_drops and all input activity.

Verification
(NUM_CH=2, SYNC_STAGES=2, ASSERT_CYCLES=4, DEASSERT_CYCLES=2, DROP_W=2)
REQ-032 sig_in[0] 0->1 held -> ready[0]=1 and rise[0] pulse exactly 6 clocks after edge; all_ready stays 0.
REQ-033 sig_in[0] high 3 cycles then low -> ready[0] and rise[0] stay 0 throughout.
REQ-034 ready[0]=1, sig_in[0] low 1 cycle -> ready unchanged, no fall; low held -> fall[0] pulse 4 clocks after edge, drop_cnt=1.
REQ-035 Both channels ready, both sig_in drop same cycle -> fall=2'b11 one cycle, drop_cnt +1 only; repeat 4 drop cycles -> drop_cnt saturates at 3.
REQ-036 clr_drops coincident with a fall -> drop_cnt=0 next cycle.
REQ-037 rst pulse while ready=2'b11 -> ready=0, fall=0, drop_cnt=0 next cycle; requalification takes full 6 clocks.

Source files
------------

// File: rtl/ready_qualifier.sv
// rtl/ready_qualifier.sv - per-channel synchronise-and-qualify of asynchronous ready levels
//
// Purpose: each raw level sig_in[i] passes through a synchroniser chain and a
// four-state qualification FSM.  ready[i] only changes after the synchronised
// level has been stable for ASSERT_CYCLES (rising) or DEASSERT_CYCLES
// (falling) consecutive samples.  Edge pulses and a saturating drop counter
// are provided alongside.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   sig_in     in   [NUM_CH]  asynchronous raw levels
//   clr_drops  in   synchronous clear of drop_cnt (wins over increment)
//   ready      out  [NUM_CH]  registered qualified levels
//   rise       out  [NUM_CH]  one-cycle pulse when ready[i] goes 0->1
//   fall       out  [NUM_CH]  one-cycle pulse when ready[i] goes 1->0
//   all_ready  out  AND of ready
//   drop_cnt   out  [DROP_W]  saturating count of cycles with any fall

module ready_qualifier #(
  parameter int NUM_CH          = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int ASSERT_CYCLES   = 4096,
  parameter int DEASSERT_CYCLES = 1,
  parameter int DROP_W          = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] sig_in,
  input  logic              clr_drops,
  output logic [NUM_CH-1:0] ready,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic              all_ready,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int MAX_CYC = (ASSERT_CYCLES > DEASSERT_CYCLES) ? ASSERT_CYCLES : DEASSERT_CYCLES;
  localparam int CTR_W   = $clog2(MAX_CYC + 1);

  localparam logic [CTR_W-1:0] CTR_ZERO = '0;
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] A_LAST   = CTR_W'(ASSERT_CYCLES - 1);
  localparam logic [CTR_W-1:0] D_LAST   = CTR_W'(DEASSERT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_QUAL_HI = 2'd1,
    ST_HIGH    = 2'd2,
    ST_QUAL_LO = 2'd3
  } state_t;

  // Synchroniser chain; stage 0 samples the raw asynchronous input.
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= sig_in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_q;
    logic [CTR_W-1:0] ctr_q;
    logic             ready_q;
    logic             rise_q;
    logic             fall_q;
    logic             s;

    assign s = sync_q[SYNC_STAGES-1][i];

    // ready/rise/fall are written on the same edge as the HIGH/LOW entry so
    // the pulse coincides with the first cycle ready shows its new value.
    // A return from QUAL_LO to HIGH never touched ready, so it pulses nothing.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= ST_LOW;
        ctr_q   <= CTR_ZERO;
        ready_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state_q)
          ST_LOW: begin
            if (s) begin
              if (ASSERT_CYCLES == 1) begin
                state_q <= ST_HIGH;
                ctr_q   <= CTR_ZERO;
                ready_q <= 1'b1;
                rise_q  <= 1'b1;
              end else begin
                state_q <= ST_QUAL_HI;
                ctr_q   <= CTR_ONE;
              end
            end else begin
              ctr_q <= CTR_ZERO;
            end
          end
          ST_QUAL_HI: begin
            if (!s) begin
              state_q <= ST_LOW;
              ctr_q   <= CTR_ZERO;
            end else if (ctr_q == A_LAST) begin
              state_q <= ST_HIGH;
              ctr_q   <= CTR_ZERO;
              ready_q <= 1'b1;
              rise_q  <= 1'b1;
            end else begin
              ctr_q <= ctr_q + CTR_ONE;
            end
          end
          ST_HIGH: begin
            if (!s) begin
              if (DEASSERT_CYCLES == 1) begin
                state_q <= ST_LOW;
                ctr_q   <= CTR_ZERO;
                ready_q <= 1'b0;
                fall_q  <= 1'b1;
              end else begin
                state_q <= ST_QUAL_LO;
                ctr_q   <= CTR_ONE;
              end
            end else begin
              ctr_q <= CTR_ZERO;
            end
          end
          ST_QUAL_LO: begin
            if (s) begin
              state_q <= ST_HIGH;
              ctr_q   <= CTR_ZERO;
            end else if (ctr_q == D_LAST) begin
              state_q <= ST_LOW;
              ctr_q   <= CTR_ZERO;
              ready_q <= 1'b0;
              fall_q  <= 1'b1;
            end else begin
              ctr_q <= ctr_q + CTR_ONE;
            end
          end
          default: begin
            state_q <= ST_LOW;
            ctr_q   <= CTR_ZERO;
            ready_q <= 1'b0;
          end
        endcase
      end
    end

    assign ready[i] = ready_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;
  end

  assign all_ready = &ready;

  // Counts cycles in which the fall output is visible, one per cycle no matter
  // how many channels fell together; holds at all-ones.
  logic [DROP_W-1:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= '0;
    end else if (clr_drops) begin
      drop_q <= '0;
    end else if ((|fall) && (drop_q != {DROP_W{1'b1}})) begin
      drop_q <= drop_q + DROP_W'(1);
    end
  end

  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_ready_qualifier.sv
// tb/tb_ready_qualifier.sv - self-checking bench for ready_qualifier
module tb_ready_qualifier;

  localparam int NCH = 2;
  localparam int SS  = 2;
  localparam int AC  = 4;
  localparam int DC  = 2;
  localparam int DW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           clr_drops;
  logic [NCH-1:0] sig_in;
  logic [NCH-1:0] ready;
  logic [NCH-1:0] rise;
  logic [NCH-1:0] fall;
  logic           all_ready;
  logic [DW-1:0]  drop_cnt;

  always #5 clk = ~clk;

  ready_qualifier #(
    .NUM_CH(NCH), .SYNC_STAGES(SS), .ASSERT_CYCLES(AC),
    .DEASSERT_CYCLES(DC), .DROP_W(DW)
  ) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .clr_drops(clr_drops),
    .ready(ready), .rise(rise), .fall(fall),
    .all_ready(all_ready), .drop_cnt(drop_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: a plain delay line for the synchroniser, then a run
  // length of consecutive samples disagreeing with the current ready level;
  // ready flips once the run reaches the qualify window for that direction.
  logic [NCH-1:0] m_pipe [SS];
  logic [NCH-1:0] m_ready, m_rise, m_fall;
  int             m_run [NCH];
  logic [DW-1:0]  m_drop;
  bit             m_valid = 1'b0;

  always @(posedge clk) begin : model
    logic [NCH-1:0] s_now, r_new;
    int             run_n [NCH];
    if (rst) begin
      for (int k = 0; k < SS; k++) m_pipe[k] <= '0;
      for (int c = 0; c < NCH; c++) m_run[c] <= 0;
      m_ready <= '0;
      m_rise  <= '0;
      m_fall  <= '0;
      m_drop  <= '0;
      m_valid <= 1'b1;
    end else begin
      s_now = m_pipe[SS-1];
      r_new = m_ready;
      for (int c = 0; c < NCH; c++) begin
        if (s_now[c] != m_ready[c]) begin
          run_n[c] = m_run[c] + 1;
          if (run_n[c] == (m_ready[c] ? DC : AC)) begin
            r_new[c] = ~m_ready[c];
            run_n[c] = 0;
          end
        end else begin
          run_n[c] = 0;
        end
        m_run[c] <= run_n[c];
      end
      m_ready <= r_new;
      m_rise  <= r_new & ~m_ready;
      m_fall  <= ~r_new & m_ready;
      if (clr_drops) m_drop <= '0;
      else if (m_fall != '0 && m_drop != {DW{1'b1}}) m_drop <= m_drop + DW'(1);
      m_pipe[0] <= sig_in;
      for (int k = 1; k < SS; k++) m_pipe[k] <= m_pipe[k-1];
    end
  end

  always @(negedge clk) begin : compare
    if (m_valid) begin
      check("model_ready", ready, m_ready);
      check("model_rise", rise, m_rise);
      check("model_fall", fall, m_fall);
      check("model_all_ready", all_ready, &m_ready);
      check("model_drop_cnt", drop_cnt, m_drop);
    end
  end

  int exp_drop [4] = '{2, 3, 3, 3};
  int hold [NCH];

  initial begin
    rst = 1'b1;
    clr_drops = 1'b0;
    sig_in = '0;
    step(3);
    check("reset_ready", ready, 0);
    check("reset_rise_fall", {rise, fall}, 0);
    check("reset_all_ready", all_ready, 0);
    check("reset_drop_cnt", drop_cnt, 0);
    rst = 1'b0;

    // Rise latency: SYNC_STAGES + ASSERT_CYCLES = 6 clocks
    sig_in[0] = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      step(1);
      if (c == 5) check("rise_lat_c5_ready", ready[0], 0);
      if (c == 6) check("rise_lat_c6_ready", ready[0], 1);
      if (c == 6) check("rise_lat_c6_rise", rise[0], 1);
      if (c == 7) check("rise_lat_c7_rise", rise[0], 0);
      check("rise_lat_all_ready", all_ready, 0);
    end

    // One-cycle low glitch while ready: no change, no fall
    sig_in[0] = 1'b0;
    step(1);
    sig_in[0] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      step(1);
      check("low_glitch_ready", ready[0], 1);
      check("low_glitch_fall", fall[0], 0);
    end

    // Held low: fall after SYNC_STAGES + DEASSERT_CYCLES = 4 clocks
    sig_in[0] = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step(1);
      if (c == 3) check("fall_lat_c3_ready", ready[0], 1);
      if (c == 4) check("fall_lat_c4_fall", fall[0], 1);
      if (c == 4) check("fall_lat_c4_ready", ready[0], 0);
      if (c == 4) check("fall_lat_c4_drop", drop_cnt, 0);
      if (c == 5) check("fall_lat_c5_fall", fall[0], 0);
      if (c == 5) check("fall_lat_c5_drop", drop_cnt, 1);
    end

    // Three-cycle high glitch: shorter than the qualify window
    sig_in[0] = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step(1);
      if (c == 3) sig_in[0] = 1'b0;
      check("high_glitch_ready", ready[0], 0);
      check("high_glitch_rise", rise[0], 0);
    end

    // Simultaneous falls count once; counter saturates at 3
    for (int r = 0; r < 4; r++) begin
      sig_in = 2'b11;
      step(8);
      check("both_ready", ready, 2'b11);
      check("both_all_ready", all_ready, 1);
      sig_in = 2'b00;
      step(4);
      check("both_fall", fall, 2'b11);
      step(1);
      check("both_fall_gone", fall, 2'b00);
      check("drop_sat_seq", drop_cnt, exp_drop[r]);
    end

    // clr_drops in the cycle a fall is shown wins over the increment
    sig_in = 2'b11;
    step(8);
    sig_in = 2'b00;
    step(4);
    check("clr_fall_seen", fall, 2'b11);
    clr_drops = 1'b1;
    step(1);
    clr_drops = 1'b0;
    check("clr_drop_cnt", drop_cnt, 0);
    step(1);
    check("clr_drop_cnt_hold", drop_cnt, 0);

    // Reset while both channels ready and drop_cnt nonzero
    sig_in = 2'b11;
    step(8);
    sig_in = 2'b01;
    step(5);
    sig_in = 2'b11;
    step(8);
    check("pre_rst_ready", ready, 2'b11);
    check("pre_rst_drop", drop_cnt, 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("rst_ready", ready, 0);
    check("rst_fall", fall, 0);
    check("rst_drop", drop_cnt, 0);
    for (int c = 1; c <= 6; c++) begin
      step(1);
      if (c == 5) check("requal_c5_ready", ready, 2'b00);
      if (c == 6) check("requal_c6_ready", ready, 2'b11);
      if (c == 6) check("requal_c6_rise", rise, 2'b11);
    end

    // Randomised activity, checked every cycle against the model
    for (int c = 0; c < NCH; c++) hold[c] = $urandom_range(1, 10);
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NCH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          sig_in[c] = ~sig_in[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 12);
        end
      end
      clr_drops = ($urandom_range(0, 60) == 0);
      rst = ($urandom_range(0, 500) == 0);
      step(1);
    end
    rst = 1'b0;
    clr_drops = 1'b0;
    step(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
